// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: CPU-priority memory port arbiter with starvation-bounded and locked-burst debug access
module mem_bus_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req_in,
    input  logic          cpu_wen_in,
    input  logic [AW-1:0] cpu_addr_in,
    input  logic [DW-1:0] cpu_data_in,
    output logic [DW-1:0] cpu_data_out,
    output logic          cpu_stall_out,
    input  logic          dbg_valid_in,
    output logic          dbg_ready_out,
    input  logic          dbg_lock_in,
    input  logic          dbg_wen_in,
    input  logic [AW-1:0] dbg_addr_in,
    input  logic [DW-1:0] dbg_data_in,
    output logic          dbg_rvalid_out,
    output logic [DW-1:0] dbg_data_out,
    output logic [AW-1:0] mem_addr_out,
    output logic [DW-1:0] mem_data_out,
    output logic          mem_wen_out,
    input  logic [DW-1:0] mem_data_in,
    output logic [15:0]   stall_cnt_out
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic {ARB_CPU, ARB_LOCK} state_t;

    state_t        state, state_d;
    logic [WW-1:0] wait_cnt;
    logic          starve, xfer;

    assign cpu_data_out = mem_data_in;

    // State register
    always_ff @(posedge clk) state <= !rst_n ? ARB_CPU : state_d;

    // Next state: a locked transfer opens a burst, dropping the lock closes it
    always_comb begin
        state_d = (state == ARB_CPU) ? ((xfer && dbg_lock_in) ? ARB_LOCK : ARB_CPU)
                                     : (dbg_lock_in ? ARB_LOCK : ARB_CPU);
    end

    // Grant, stall and memory mux; reset holds the port idle
    always_comb begin
        starve        = wait_cnt == WAIT_MAX;
        dbg_ready_out = rst_n && (state == ARB_LOCK || !cpu_req_in || starve || dbg_lock_in);
        xfer          = dbg_valid_in && dbg_ready_out;
        cpu_stall_out = rst_n && cpu_req_in && (state == ARB_LOCK || xfer);
        mem_addr_out  = xfer ? dbg_addr_in : cpu_addr_in;
        mem_data_out  = xfer ? dbg_data_in : cpu_data_in;
        mem_wen_out   = !rst_n ? 1'b1 : xfer ? dbg_wen_in : cpu_req_in ? cpu_wen_in : 1'b1;
    end

    // Consecutive refusals of a pending debug request while the CPU has priority
    always_ff @(posedge clk) begin
        if (!rst_n || xfer || !dbg_valid_in || (state == ARB_LOCK && !dbg_lock_in))
            wait_cnt <= '0;
        else if (state == ARB_CPU && !dbg_ready_out && !starve)
            wait_cnt <= wait_cnt + WW'(1);
    end

    // Debug read capture and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_rvalid_out <= 1'b0;
            dbg_data_out   <= '0;
            stall_cnt_out  <= '0;
        end else begin
            dbg_rvalid_out <= xfer && dbg_wen_in;
            if (xfer && dbg_wen_in)
                dbg_data_out <= mem_data_in;
            if (cpu_stall_out && stall_cnt_out != 16'hFFFF)
                stall_cnt_out <= stall_cnt_out + 16'd1;
        end
    end
endmodule
